// File: rtl/lif_pkg.sv
// Shared types and saturating 8-bit helpers for the LIF spike scheduler.
package lif_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    REFRACT = 1'b1
  } state_e;

  localparam int POT_W = 8;
  localparam logic [POT_W-1:0] POT_MAX = 8'd255;

  function automatic logic [POT_W-1:0] sat_add8(input logic [POT_W-1:0] a,
                                                input logic [POT_W-1:0] b);
    logic [POT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[POT_W] ? POT_MAX : s[POT_W-1:0];
  endfunction

  function automatic logic [POT_W-1:0] sat_sub8(input logic [POT_W-1:0] a,
                                                input logic [POT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/lif_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module lif_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               vld
);

  always_comb begin
    logic [SRC_W:0]   pos;
    logic [SRC_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, ptr} + (SRC_W+1)'(k);
      if (pos >= (SRC_W+1)'(NUM_SRC)) pos = pos - (SRC_W+1)'(NUM_SRC);
      idx = pos[SRC_W-1:0];
      if (en && !vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lif_spike_scheduler.sv
// Shared LIF membrane datapath: round-robin grants, weighted saturating
// integration, periodic leak, threshold fire and refractory hold-off.
module lif_spike_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = $clog2(NUM_SRC),
  parameter int LEAK           = 1,
  parameter int LEAK_PERIOD    = 1000,
  parameter int REFRACT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [NUM_SRC*8-1:0] cfg_weight,
  input  logic [7:0]           cfg_threshold,
  output logic [NUM_SRC-1:0]   ack,
  output logic                 spike_out,
  output logic [SRC_W-1:0]     spike_src,
  output logic [7:0]           potential,
  output logic                 busy,
  output logic [15:0]          spike_count
);

  localparam int TICK_W = $clog2(LEAK_PERIOD);
  localparam int RC_W   = (REFRACT_CYCLES < 1) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam logic [POT_W-1:0] LEAK_V = POT_W'(LEAK);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                leak_pend_q, leak_pend_d;
  logic [RC_W-1:0]     refr_q, refr_d;
  logic [NUM_SRC-1:0]  ack_q, ack_d;
  logic                spike_q, spike_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [POT_W-1:0]    pot_q, pot_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [POT_W-1:0]    w_arr [NUM_SRC];
  logic [NUM_SRC-1:0]  arb_gnt;
  logic [SRC_W-1:0]    arb_idx;
  logic                arb_vld;
  logic                arb_en;
  logic                wrap;
  logic [POT_W-1:0]    sum;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) w_arr[i] = cfg_weight[8*i +: 8];
  end

  // A source whose ack is currently high is masked so it cannot win twice in a row.
  assign arb_en = (state_q == IDLE) && !leak_pend_q;

  lif_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req     (req & ~ack_q),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  assign wrap = (tick_q == TICK_W'(LEAK_PERIOD - 1));
  assign sum  = sat_add8(pot_q, w_arr[arb_idx]);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tick_d      = wrap ? '0 : tick_q + TICK_W'(1);
    leak_pend_d = leak_pend_q;
    refr_d      = refr_q;
    ack_d       = '0;
    spike_d     = 1'b0;
    src_d       = src_q;
    pot_d       = pot_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        leak_pend_d = wrap;
        if (leak_pend_q) begin
          pot_d = sat_sub8(pot_q, LEAK_V);
        end else if (arb_vld) begin
          ack_d = arb_gnt;
          ptr_d = (arb_idx == SRC_W'(NUM_SRC - 1)) ? '0 : arb_idx + SRC_W'(1);
          if (sum >= cfg_threshold) begin
            pot_d   = '0;
            spike_d = 1'b1;
            src_d   = arb_idx;
            cnt_d   = cnt_q + 16'd1;
            if (REFRACT_CYCLES > 0) begin
              state_d = REFRACT;
              refr_d  = RC_W'(REFRACT_CYCLES);
            end
          end else begin
            pot_d = sum;
          end
        end
      end
      REFRACT: begin
        pot_d       = '0;
        leak_pend_d = 1'b0;
        refr_d      = refr_q - RC_W'(1);
        if (refr_q == RC_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tick_q      <= '0;
      leak_pend_q <= 1'b0;
      refr_q      <= '0;
      ack_q       <= '0;
      spike_q     <= 1'b0;
      src_q       <= '0;
      pot_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tick_q      <= tick_d;
      leak_pend_q <= leak_pend_d;
      refr_q      <= refr_d;
      ack_q       <= ack_d;
      spike_q     <= spike_d;
      src_q       <= src_d;
      pot_q       <= pot_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign spike_out   = spike_q;
  assign spike_src   = src_q;
  assign potential   = pot_q;
  assign busy        = (state_q == REFRACT);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_spike_scheduler.sv
// Directed and randomized bench for lif_spike_scheduler with a cycle-level
// behavioural reference model.
module tb_lif_spike_scheduler;

  localparam int N  = 4;
  localparam int LP = 10;
  localparam int RC = 16;
  localparam int LK = 1;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N*8-1:0] cfg_weight;
  logic [7:0]   cfg_threshold;
  logic [N-1:0] ack;
  logic         spike_out;
  logic [1:0]   spike_src;
  logic [7:0]   potential;
  logic         busy;
  logic [15:0]  spike_count;

  lif_spike_scheduler #(
    .NUM_SRC        (N),
    .LEAK           (LK),
    .LEAK_PERIOD    (LP),
    .REFRACT_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .cfg_weight    (cfg_weight),
    .cfg_threshold (cfg_threshold),
    .ack           (ack),
    .spike_out     (spike_out),
    .spike_src     (spike_src),
    .potential     (potential),
    .busy          (busy),
    .spike_count   (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] w [N];
  logic [7:0] thr;

  // Reference model state, derived from the behavioural rules.
  int         m_pot, m_cnt, m_ptr, m_tick, m_refr, m_src;
  bit         m_pend, m_inref, m_spk;
  logic [N-1:0] m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit           wr;
    int           g, s, i;
    logic [N-1:0] nack;
    bit           nspk;
    if (!reset_n) begin
      m_pot = 0; m_cnt = 0; m_ptr = 0; m_tick = 0; m_refr = 0; m_src = 0;
      m_pend = 0; m_inref = 0; m_spk = 0; m_ack = '0;
      return;
    end
    wr   = (m_tick == LP - 1);
    nack = '0;
    nspk = 0;
    if (m_inref) begin
      m_pot  = 0;
      m_pend = 0;
      if (m_refr == 1) m_inref = 0;
      m_refr = m_refr - 1;
    end else if (m_pend) begin
      m_pot  = (m_pot > LK) ? m_pot - LK : 0;
      m_pend = wr;
    end else begin
      m_pend = wr;
      g = -1;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (g < 0 && req[i] && !m_ack[i]) g = i;
      end
      if (g >= 0) begin
        nack[g] = 1'b1;
        m_ptr   = (g + 1) % N;
        s = m_pot + int'(w[g]);
        if (s > 255) s = 255;
        if (s >= int'(thr)) begin
          m_pot = 0;
          nspk  = 1;
          m_src = g;
          m_cnt = (m_cnt + 1) % 65536;
          if (RC > 0) begin
            m_inref = 1;
            m_refr  = RC;
          end
        end else begin
          m_pot = s;
        end
      end
    end
    m_tick = (m_tick + 1) % LP;
    m_ack  = nack;
    m_spk  = nspk;
  endtask

  task automatic step(input logic [N-1:0] r);
    req           = r;
    cfg_weight    = {w[3], w[2], w[1], w[0]};
    cfg_threshold = thr;
    @(posedge clk);
    model_edge();
    #1;
    chk("ack",         32'(ack),         32'(m_ack));
    chk("spike_out",   32'(spike_out),   32'(m_spk));
    chk("spike_src",   32'(spike_src),   32'(m_src));
    chk("potential",   32'(potential),   32'(m_pot));
    chk("busy",        32'(busy),        32'(m_inref));
    chk("spike_count", 32'(spike_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step('0);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 40; c++) begin
      if (!busy) break;
      step('0);
    end
    chk(tag, 32'(c < 40), 32'd1);
  endtask

  initial begin
    int busy_n, first_idle, first_ack, c;
    int order[$];
    int exp_rr[5];
    logic [N-1:0] prev;
    logic [N-1:0] r;

    exp_rr = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) w[i] = 8'd0;
    thr = 8'd255;
    step('0);
    step('0);
    chk("rst_potential", 32'(potential), 32'd0);
    chk("rst_count",     32'(spike_count), 32'd0);
    reset_n = 1'b1;

    // Accumulate and fire
    do_reset();
    w[0] = 8'd20; thr = 8'd100;
    for (int p = 0; p < 5; p++) begin
      step(4'b0001);
      if (p < 4) begin
        chk("acc_potential", 32'(potential), 32'(20 * (p + 1)));
        step('0);
      end else begin
        chk("fire_spike", 32'(spike_out), 32'd1);
        chk("fire_src",   32'(spike_src), 32'd0);
        chk("fire_pot",   32'(potential), 32'd0);
        chk("fire_count", 32'(spike_count), 32'd1);
      end
    end
    busy_n = busy ? 1 : 0;
    for (c = 0; c < 40; c++) begin
      step('0);
      if (busy) busy_n++;
      else break;
    end
    chk("refract_len", 32'(busy_n), 32'd16);

    // Round-robin order
    do_reset();
    for (int i = 0; i < N; i++) w[i] = 8'd1;
    thr = 8'd255;
    prev = '0;
    for (int k = 0; k < 20 && order.size() < 5; k++) begin
      step(4'hF & ~ack);
      chk("rr_no_repeat", 32'(ack & prev), 32'd0);
      for (int i = 0; i < N; i++) if (ack[i]) order.push_back(i);
      prev = ack;
    end
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(exp_rr[i]));

    // Saturation
    do_reset();
    w[1] = 8'd200; thr = 8'd255;
    step(4'b0010);
    chk("sat_pot1", 32'(potential), 32'd200);
    step('0);
    step(4'b0010);
    chk("sat_spike", 32'(spike_out), 32'd1);
    chk("sat_pot2",  32'(potential), 32'd0);
    chk("sat_src",   32'(spike_src), 32'd1);
    wait_idle("sat_drain");

    // Leak timing and leak/request collision
    do_reset();
    w[0] = 8'd3; thr = 8'd255;
    step(4'b0001);
    chk("leak_start", 32'(potential), 32'd3);
    for (int k = 2; k <= 52; k++) begin
      r = (k >= 51) ? (4'b0001 & ~ack) : 4'b0000;
      step(r);
      if (k == 10) chk("leak_e10", 32'(potential), 32'd3);
      if (k == 11) chk("leak_e11", 32'(potential), 32'd2);
      if (k == 21) chk("leak_e21", 32'(potential), 32'd1);
      if (k == 31) chk("leak_e31", 32'(potential), 32'd0);
      if (k == 41) chk("leak_e41", 32'(potential), 32'd0);
      if (k == 51) chk("leak_first_ack", 32'(ack), 32'd0);
      if (k == 52) begin
        chk("leak_late_ack", 32'(ack), 32'b0001);
        chk("leak_late_pot", 32'(potential), 32'd3);
      end
    end
    step('0);

    // Refractory hold-off
    w[2] = 8'd50; thr = 8'd50;
    for (c = 0; c < 20; c++) begin
      step(4'b0100 & ~ack);
      if (spike_out) break;
    end
    chk("ref_fired", 32'(spike_out), 32'd1);
    step('0); step('0); step('0);
    first_idle = -1; first_ack = -1;
    for (c = 0; c < 40; c++) begin
      step(4'b0100 & ~ack);
      if (first_idle < 0 && busy) chk("ref_no_ack", 32'(ack), 32'd0);
      if (first_idle < 0 && !busy) first_idle = c;
      if (ack[2]) begin
        first_ack = c;
        break;
      end
    end
    chk("ref_idle_seen", 32'(first_idle >= 0), 32'd1);
    chk("ref_ack_timing", 32'(first_ack), 32'(first_idle + 1));

    // Reset in the middle of REFRACT (counter at 8)
    for (int k = 0; k < 8; k++) step('0);
    chk("mid_ref_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step('0);
    chk("mr_ack",   32'(ack), 32'd0);
    chk("mr_spike", 32'(spike_out), 32'd0);
    chk("mr_src",   32'(spike_src), 32'd0);
    chk("mr_pot",   32'(potential), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_count", 32'(spike_count), 32'd0);
    reset_n = 1'b1;
    step(4'hF & ~ack);
    chk("mr_first_grant", 32'(ack), 32'b0001);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) w[$urandom_range(0, N - 1)] = 8'($urandom_range(0, 80));
      if ($urandom_range(0, 19) == 0) thr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      reset_n = ($urandom_range(0, 149) != 0);
      r = 4'($urandom) & ~ack;
      step(r);
    end
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_spike_scheduler.md
Name: lif_spike_scheduler

Overview:
- Shares one LIF membrane-update datapath among NUM_SRC spike requesters, such as debounced and edge-detected buttons or upstream neurons.
- Arbitrates requests round-robin, applies a per-source weight with saturation, and schedules periodic leak ticks.
- Detects threshold crossings and enforces a refractory period after each fire.
- Sits between the input conditioning logic and the LED/debug outputs in the top level.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- SRC_W, $clog2(NUM_SRC), width of the source index.
- LEAK, 1, amount subtracted from the potential per leak tick.
- LEAK_PERIOD, 1000, clock cycles between leak ticks (>=2).
- REFRACT_CYCLES, 16, cycles in REFRACT after a fire (0 = no refractory).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_SRC  per-source spike request, level
- cfg_weight  in  NUM_SRC*8  packed per-source increment; slice i = bits [8i+7:8i]; sampled at grant
- cfg_threshold  in  8  fire threshold; sampled at grant
- ack  out  NUM_SRC  one-hot, 1-cycle grant pulse
- spike_out  out  1  1-cycle fire pulse
- spike_src  out  SRC_W  source whose grant caused the last fire
- potential  out  8  current membrane potential
- busy  out  1  high while state != IDLE
- spike_count  out  16  fires since reset, wraps at 65535->0

Behaviour:
- Reset: one clock and a synchronous active-low reset. reset_n low at a posedge sets:
  - ack, spike_out, spike_src, potential, spike_count = 0
  - state = IDLE, round-robin pointer = 0
  - tick counter = 0, leak_pending = 0, refractory counter = 0
  - Reset wins over every other event in any state.
- States: IDLE, REFRACT.
- Leak timer: free-running counter 0..LEAK_PERIOD-1 in all non-reset cycles. On wrap it sets leak_pending. A second wrap while already pending coalesces into one tick.
- IDLE priority:
  1. leak_pending: potential <= (potential > LEAK) ? potential-LEAK : 0. leak_pending cleared. No grant this cycle.
  2. Else eligible request present: grant one source g.
- Eligibility: req[i]=1 and ack[i]=0 in the current cycle. Requesters deassert req in the cycle their ack is high, so no source is granted in two consecutive cycles.
- Round-robin: search starts at the pointer. After granting g, pointer <= (g+1) mod NUM_SRC.
- Grant at a posedge:
  - ack[g] <= 1 for exactly one cycle.
  - sum = potential + weight[g], computed 9-bit and saturated to 255.
  - sum < cfg_threshold: potential <= sum, stay IDLE.
  - sum >= cfg_threshold:
    - potential <= 0, spike_out <= 1 for one cycle, spike_src <= g, spike_count++.
    - If REFRACT_CYCLES > 0: state <= REFRACT, refractory counter <= REFRACT_CYCLES. Otherwise stay IDLE.
  - cfg_threshold = 0: every grant fires.
- Latency: req high in cycle N with no leak pending -> ack, potential update and spike_out all visible in cycle N+1.
- REFRACT:
  - No grants; req is held off, not dropped.
  - potential held at 0.
  - A leak wrap does not set leak_pending, and any pending flag is cleared.
  - Counter decrements each cycle; at 1 -> IDLE. REFRACT lasts exactly REFRACT_CYCLES cycles, and the first grant can issue in the following cycle.
- spike_src holds its value until the next fire.
- busy = (state == REFRACT).

Decomposition:
- Shared package lif_pkg:
  - state enum (IDLE, REFRACT)
  - POT_W = 8, POT_MAX = 255
  - functions sat_add8 and sat_sub8 (floor at 0)
- One sub-module: lif_rr_arbiter.
  - Parameter NUM_SRC.
  - Inputs: req mask, pointer, enable.
  - Outputs: one-hot grant, grant index, valid.
  - Purely combinational. The pointer register lives in the scheduler.

Test Plan:
- Accumulate and fire: weight0=20, thr=100, five single req0 pulses -> potential 20/40/60/80, then spike_out=1, spike_src=0, potential=0, spike_count=1, busy high for exactly 16 cycles.
- Round-robin: req[3:0] all requesting, each dropping after its ack and re-raising -> ack order 0,1,2,3,0; no source acked in consecutive cycles.
- Saturation: weight1=200, thr=255, two req1 grants -> potential 200, then sum 400 clipped to 255 >= 255 -> fire, potential 0.
- Leak timing and collision (LEAK_PERIOD=10): potential 3 with no req -> 2, 1, 0 on successive ticks, then stays 0. A req in the same IDLE cycle as leak_pending -> leak applied first, ack one cycle later.
- Refractory hold-off: req2 raised 3 cycles after a fire, REFRACT_CYCLES=16 -> no ack during REFRACT; ack2 in the first IDLE cycle; leak wraps inside REFRACT leave leak_pending=0.
- Reset mid-REFRACT: reset_n low for 1 cycle at refractory count 8 -> all outputs 0, IDLE; next simultaneous req[3:0] grants source 0 first.
